// File: rtl/button_pkg.sv
// button_pkg
// Shared definitions for the push-button front end: the FSM state
// encoding used by button_events (also visible on its debug `state`
// port) and the idle value of the button synchronizer.
package button_pkg;

  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE     = 3'd0,
    PRESS_DB = 3'd1,
    HELD     = 3'd2,
    LONG     = 3'd3,
    REL_DB   = 3'd4
  } state_e;

  // The pin is active-low, so a synchronizer that resets to 1 looks
  // like a released button until the first real samples arrive.
  localparam logic SYNC_RST_VAL = 1'b1;

endpackage

// File: rtl/button_events_sync_2ff.sv
// sync_2ff
// Generic two-flop synchronizer for bringing asynchronous pins into the
// clk domain. The flops reset to RST_VAL so a downstream consumer sees a
// known idle level during and right after reset.
//
// Ports:
//   clk   in   destination clock
//   rst_n in   asynchronous active-low reset
//   d     in   asynchronous input, WIDTH bits
//   q     out  synchronized output, WIDTH bits, two clk edges of latency
module sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_events.sv
// button_events
// Debounces the raw active-low push-button and classifies each press as
// a short press (pulse on release) or a long press (pulse when the hold
// time is reached). The board FSM uses these pulses as start/shutdown.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   LONG_CYCLES      debounced hold time for a long press (> DEBOUNCE_CYCLES)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   btn_n        in   raw button pin, asynchronous, low = pressed
//   btn_level    out  debounced button level, 1 = pressed
//   short_pulse  out  one-cycle pulse on a debounced release of a short press
//   long_pulse   out  one-cycle pulse when a debounced hold reaches LONG_CYCLES
//   state        out  current FSM state (debug / LEDs)
//
// Build option:
//   BUTTON_LONG_PRESS_EN  when defined, long-press detection is built in.
//   When undefined, long_pulse is tied low and every debounced release
//   produces short_pulse.
module button_events
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_n,
  output logic                  btn_level,
  output logic                  short_pulse,
  output logic                  long_pulse,
  output logic [STATE_BITS-1:0] state
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Illegal parameter combinations would make the hold counter unable to
  // outlast the debounce window, so refuse to elaborate them.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_cfg
    $error("button_events: need DEBOUNCE_CYCLES >= 2 and LONG_CYCLES > DEBOUNCE_CYCLES");
  end

  logic btn_sync_n;
  logic btn_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (SYNC_RST_VAL)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_n),
    .q     (btn_sync_n)
  );

  assign btn_s = ~btn_sync_n;

  state_e          state_q, state_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            btn_level_q, btn_level_d;
  logic            short_pulse_q, short_pulse_d;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_flag_q, long_flag_d;
  logic              long_pulse_q, long_pulse_d;
`endif

  // Next-state logic. Counters only advance while below their terminal
  // value, so they saturate instead of wrapping. A bounce during release
  // debounce returns to the holding state without touching hold_cnt.
  always_comb begin
    state_d       = state_q;
    db_cnt_d      = db_cnt_q;
    btn_level_d   = btn_level_q;
    short_pulse_d = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
    hold_cnt_d    = hold_cnt_q;
    long_flag_d   = long_flag_q;
    long_pulse_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d  = PRESS_DB;
          db_cnt_d = '0;
        end
      end

      PRESS_DB: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = HELD;
          btn_level_d = 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
          hold_cnt_d  = '0;
`endif
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      HELD: begin
        if (!btn_s) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
`ifdef BUTTON_LONG_PRESS_EN
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d      = LONG;
          long_pulse_d = 1'b1;
          long_flag_d  = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
`endif
        end
      end

`ifdef BUTTON_LONG_PRESS_EN
      LONG: begin
        if (!btn_s) begin
          state_d  = REL_DB;
          db_cnt_d = '0;
        end
      end
`endif

      REL_DB: begin
        if (btn_s) begin
`ifdef BUTTON_LONG_PRESS_EN
          state_d  = long_flag_q ? LONG : HELD;
`else
          state_d  = HELD;
`endif
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          state_d     = IDLE;
          btn_level_d = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
          short_pulse_d = ~long_flag_q;
          long_flag_d   = 1'b0;
`else
          short_pulse_d = 1'b1;
`endif
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      // Unused encodings recover to a clean idle with the level released.
      default: begin
        state_d     = IDLE;
        btn_level_d = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
        long_flag_d = 1'b0;
`endif
      end
    endcase
  end

  // All state, counters and outputs are registered here, so no path
  // exists from btn_n to an output without passing through a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      db_cnt_q      <= '0;
      btn_level_q   <= 1'b0;
      short_pulse_q <= 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
      hold_cnt_q    <= '0;
      long_flag_q   <= 1'b0;
      long_pulse_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      db_cnt_q      <= db_cnt_d;
      btn_level_q   <= btn_level_d;
      short_pulse_q <= short_pulse_d;
`ifdef BUTTON_LONG_PRESS_EN
      hold_cnt_q    <= hold_cnt_d;
      long_flag_q   <= long_flag_d;
      long_pulse_q  <= long_pulse_d;
`endif
    end
  end

  assign btn_level   = btn_level_q;
  assign short_pulse = short_pulse_q;
  assign state       = state_q;
`ifdef BUTTON_LONG_PRESS_EN
  assign long_pulse  = long_pulse_q;
`else
  assign long_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_button_events.sv
// tb_button_events
// Self-checking bench for button_events with DEBOUNCE_CYCLES=4 and
// LONG_CYCLES=20. A behavioural model tracks the debounced level from
// run lengths of the synchronized pin and accumulates hold time; every
// clock edge the DUT outputs are compared against it, and directed
// scenarios additionally check latencies and pulse counts.
// Honours BUTTON_LONG_PRESS_EN in the same way as the design.
module tb_button_events;

  localparam int D = 4;
  localparam int L = 20;

`ifdef BUTTON_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  localparam int S_IDLE     = 0;
  localparam int S_PRESS_DB = 1;
  localparam int S_HELD     = 2;
  localparam int S_LONG     = 3;
  localparam int S_REL_DB   = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_n = 1'b1;
  logic       btn_level;
  logic       short_pulse;
  logic       long_pulse;
  logic [2:0] state;

  button_events #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_n       (btn_n),
    .btn_level   (btn_level),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .state       (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pin history (two-sample delay), debounced level,
  // length of the current disagreeing run, accumulated hold time.
  bit pin_hist[$];
  bit m_lvl;
  bit m_long_done;
  bit m_short;
  bit m_long;
  int m_run;
  int m_hold;

  // Event bookkeeping for directed latency / count checks.
  int   edges_since_change;
  int   rise_cnt, fall_cnt, short_cnt, long_cnt;
  int   rise_at, fall_at, short_at, long_at;
  logic prev_level;

  task automatic modelReset();
    pin_hist    = {1'b1, 1'b1};
    m_lvl       = 1'b0;
    m_long_done = 1'b0;
    m_short     = 1'b0;
    m_long      = 1'b0;
    m_run       = 0;
    m_hold      = 0;
  endtask

  // A level change is accepted after D+1 consecutive disagreeing samples
  // (one to notice, D to confirm). Hold time accrues only on agreeing
  // samples that are not ending a release bounce.
  task automatic modelStep();
    bit s;
    if (!rst_n) begin
      modelReset();
      return;
    end
    s = !pin_hist.pop_front();
    pin_hist.push_back(btn_n);
    m_short = 1'b0;
    m_long  = 1'b0;
    if (s != m_lvl) begin
      m_run++;
      if (m_run == D + 1) begin
        m_run = 0;
        if (!m_lvl) begin
          m_lvl  = 1'b1;
          m_hold = 0;
        end else begin
          m_lvl       = 1'b0;
          m_short     = !m_long_done;
          m_long_done = 1'b0;
        end
      end
    end else begin
      if (m_lvl && m_run == 0 && LONG_EN && !m_long_done) begin
        m_hold++;
        if (m_hold == L) begin
          m_long_done = 1'b1;
          m_long      = 1'b1;
        end
      end
      m_run = 0;
    end
  endtask

  function automatic int modelState();
    if (!m_lvl) return (m_run == 0) ? S_IDLE : S_PRESS_DB;
    if (m_run != 0) return S_REL_DB;
    return m_long_done ? S_LONG : S_HELD;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearEvents();
    edges_since_change = 0;
    rise_cnt  = 0;
    fall_cnt  = 0;
    short_cnt = 0;
    long_cnt  = 0;
    rise_at   = -1;
    fall_at   = -1;
    short_at  = -1;
    long_at   = -1;
    prev_level = btn_level;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("btn_level", btn_level, m_lvl);
    checkOutput("short_pulse", short_pulse, m_short);
    checkOutput("long_pulse", long_pulse, m_long);
    checkOutput("state", state, modelState());
    edges_since_change++;
    if (btn_level === 1'b1 && prev_level !== 1'b1) begin
      rise_cnt++;
      rise_at = edges_since_change;
    end
    if (btn_level === 1'b0 && prev_level === 1'b1) begin
      fall_cnt++;
      fall_at = edges_since_change;
    end
    prev_level = btn_level;
    if (short_pulse === 1'b1) begin
      short_cnt++;
      short_at = edges_since_change;
    end
    if (long_pulse === 1'b1) begin
      long_cnt++;
      long_at = edges_since_change;
    end
  endtask

  task automatic applyStimulus(input logic level, input int cycles);
    if (level !== btn_n) edges_since_change = 0;
    btn_n = level;
    repeat (cycles) tick();
  endtask

  task automatic doReset(input int cycles);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_btn_level", btn_level, 0);
    checkOutput("rst_short_pulse", short_pulse, 0);
    checkOutput("rst_long_pulse", long_pulse, 0);
    checkOutput("rst_state", state, S_IDLE);
    repeat (cycles) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    modelReset();
    #2;

    // Reset with the button released, then sit idle.
    doReset(3);
    clearEvents();
    applyStimulus(1'b1, 50);
    checkOutput("idle_rises", rise_cnt, 0);
    checkOutput("idle_pulses", short_cnt + long_cnt, 0);

    // Short press: 10 cycles low.
    clearEvents();
    applyStimulus(1'b0, 10);
    checkOutput("short_press_latency", rise_at, D + 3);
    clearEvents();
    applyStimulus(1'b1, 12);
    checkOutput("short_release_latency", fall_at, D + 3);
    checkOutput("short_pulse_at", short_at, D + 3);
    checkOutput("short_pulse_count", short_cnt, 1);
    checkOutput("short_no_long", long_cnt, 0);

    // Long press: 30 cycles low.
    clearEvents();
    applyStimulus(1'b0, 30);
    checkOutput("long_press_latency", rise_at, D + 3);
    checkOutput("long_pulse_at", long_at, LONG_EN ? D + L + 3 : -1);
    checkOutput("long_pulse_count", long_cnt, LONG_EN ? 1 : 0);
    clearEvents();
    applyStimulus(1'b1, 12);
    checkOutput("long_release_fall", fall_at, D + 3);
    checkOutput("long_release_short", short_cnt, LONG_EN ? 0 : 1);

    // Glitches shorter than the debounce window.
    clearEvents();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 2);
    end
    applyStimulus(1'b1, 10);
    checkOutput("glitch_rises", rise_cnt, 0);
    checkOutput("glitch_pulses", short_cnt + long_cnt, 0);

    // Held press with a 2-cycle bounce high.
    clearEvents();
    applyStimulus(1'b0, 12);
    applyStimulus(1'b1, 2);
    applyStimulus(1'b0, 30);
    checkOutput("bounce_rises", rise_cnt, 1);
    checkOutput("bounce_falls", fall_cnt, 0);
    checkOutput("bounce_short", short_cnt, 0);
    checkOutput("bounce_long", long_cnt, LONG_EN ? 1 : 0);
    clearEvents();
    applyStimulus(1'b1, 12);
    checkOutput("bounce_release_fall", fall_cnt, 1);
    checkOutput("bounce_release_short", short_cnt, LONG_EN ? 0 : 1);

    // Reset in the middle of a hold, button stays pressed.
    clearEvents();
    applyStimulus(1'b0, 10);
    doReset(3);
    clearEvents();
    applyStimulus(1'b0, 10);
    checkOutput("rehold_latency", rise_at, D + 3);
    checkOutput("rehold_pulses", short_cnt + long_cnt, 0);
    applyStimulus(1'b1, 12);

    // Randomized run lengths, with an occasional reset.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        doReset(2);
        clearEvents();
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(1, 35));
    end
    applyStimulus(1'b1, 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
